// File: rtl/useq_uart_bridge.sv
// 8N1 UART front end for the useq host FIFO: received bytes are pushed into the
// core FIFO, and bytes popped from the core FIFO are transmitted on uart_tx.
module useq_uart_bridge #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       write_fifo,
  output logic [7:0] fifo_in,
  input  logic       fifo_full,
  output logic       read_fifo,
  input  logic [7:0] fifo_out,
  input  logic       fifo_empty,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic [1:0] rx_state_dbg,
  output logic [2:0] tx_state_dbg
);

  // Handshake: write_fifo is a one-cycle push, only issued while fifo_full is low,
  // with fifo_in valid in that cycle. read_fifo is a one-cycle pop, only issued
  // while fifo_empty is low; fifo_out is valid the cycle after the pop strobe.

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_POP   = 3'd1;
  localparam logic [2:0] TX_LOAD  = 3'd2;
  localparam logic [2:0] TX_START = 3'd3;
  localparam logic [2:0] TX_DATA  = 3'd4;
  localparam logic [2:0] TX_STOP  = 3'd5;

  logic          rx_meta;
  logic          rx_sync;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          hold_valid;
  logic [7:0]    hold_data;

  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;
  assign tx_busy      = (tx_state != TX_IDLE);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'd0;
      rx_frame_err <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit is treated as a glitch.
          if (rx_cnt == BIT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at the mid-stop sample so the next start edge is not missed.
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rx_sync) begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic rx_good_byte;
  assign rx_good_byte = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

  // One-byte holding register between the receiver and the core FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
      write_fifo <= 1'b0;
      fifo_in    <= 8'd0;
      rx_overrun <= 1'b0;
    end else begin
      write_fifo <= 1'b0;
      if (hold_valid && !fifo_full) begin
        write_fifo <= 1'b1;
        fifo_in    <= hold_data;
        hold_valid <= 1'b0;
      end
      if (rx_good_byte) begin
        if (hold_valid) begin
          rx_overrun <= 1'b1;
        end else begin
          hold_valid <= 1'b1;
          hold_data  <= rx_shift;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'd0;
      uart_tx   <= 1'b1;
      read_fifo <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (read_fifo) begin
            read_fifo <= 1'b0;
            tx_state  <= TX_POP;
          end else begin
            read_fifo <= !fifo_empty;
          end
        end
        TX_POP: begin
          // fifo_out is guaranteed valid in this cycle, so take it here.
          tx_shift <= fifo_out;
          tx_state <= TX_LOAD;
        end
        TX_LOAD: begin
          uart_tx  <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_START;
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          // Issue the next pop on the way out so back-to-back frames have one idle cycle.
          if (tx_cnt == BIT_LAST) begin
            tx_cnt    <= '0;
            tx_state  <= TX_IDLE;
            read_fifo <= !fifo_empty;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_useq_uart_bridge.sv
// Directed bench for useq_uart_bridge at 16 clocks per bit: RX push path,
// TX pop path, backpressure, framing, reset mid-frame and full duplex.
module tb_useq_uart_bridge;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_out = 8'd0;
  logic       uart_tx;
  logic       write_fifo;
  logic [7:0] fifo_in;
  logic       read_fifo;
  logic       tx_busy;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic [1:0] rx_state_dbg;
  logic [2:0] tx_state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] push_q[$];
  logic [7:0] exp_q[$];
  int         strobe_viol = 0;
  logic       prev_wr = 1'b0;
  logic       prev_rd = 1'b0;

  useq_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .write_fifo(write_fifo),
    .fifo_in(fifo_in),
    .fifo_full(fifo_full),
    .read_fifo(read_fifo),
    .fifo_out(fifo_out),
    .fifo_empty(fifo_empty),
    .tx_busy(tx_busy),
    .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err),
    .rx_state_dbg(rx_state_dbg),
    .tx_state_dbg(tx_state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Push monitor and strobe-width monitor
  always @(negedge clk) begin
    if (write_fifo) push_q.push_back(fifo_in);
    if ((write_fifo && prev_wr) || (read_fifo && prev_rd)) strobe_viol++;
    prev_wr = write_fifo;
    prev_rd = read_fifo;
  end

  // Driver: one 8N1 frame on uart_rx followed by one idle bit time
  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Driver: offer one byte to the pop port, then observe the line for stop_at cycles
  // after the pop strobe (t=0 is the read_fifo cycle).
  task automatic tx_frame(input logic [7:0] data, input int stop_at,
                          output int got_pop, output int line_err,
                          output int busy_cnt, output int busy_first,
                          output logic t2_line, output logic t3_line,
                          output int extra_pops);
    logic [9:0] frame;
    logic       exp;
    int         i;
    frame = {1'b1, data, 1'b0};
    got_pop = 0; line_err = 0; busy_cnt = 0; busy_first = 0;
    t2_line = 1'bx; t3_line = 1'bx; extra_pops = 0;
    @(posedge clk); #1 fifo_empty = 1'b0;
    i = 0;
    while (got_pop == 0 && i < 40) begin
      @(negedge clk);
      if (read_fifo) got_pop = 1;
      i++;
    end
    @(posedge clk); #1;
    fifo_empty = 1'b1;
    fifo_out = data;
    if (got_pop == 1) begin
      for (int t = 1; t <= stop_at; t++) begin
        @(negedge clk);
        exp = (t >= 3 && t <= 2 + 10 * CPB) ? frame[(t - 3) / CPB] : 1'b1;
        if (uart_tx !== exp) line_err++;
        if (tx_busy) begin
          busy_cnt++;
          if (busy_first == 0) busy_first = t;
        end
        if (read_fifo) extra_pops++;
        if (t == 2) t2_line = uart_tx;
        if (t == 3) t3_line = uart_tx;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    n_checks++; if (write_fifo !== 1'b0) begin n_fail++; $display("FAIL reset_write_fifo: got %b expected 0", write_fifo); end
    n_checks++; if (read_fifo !== 1'b0) begin n_fail++; $display("FAIL reset_read_fifo: got %b expected 0", read_fifo); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    n_checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {rx_overrun, rx_frame_err}); end
    n_checks++; if (fifo_in !== 8'h00) begin n_fail++; $display("FAIL reset_fifo_in: got %h expected 00", fifo_in); end
  endtask

  task automatic test_loopback;
    push_q.delete(); exp_q.delete();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (push_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL loopback_count: got %0d expected %0d", push_q.size(), exp_q.size()); end
    if (push_q.size() > 0) begin
      n_checks++; if (push_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL loopback_data: got %h expected %h", push_q[0], exp_q[0]); end
    end
    n_checks++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL loopback_frame_err: got %b expected 0", rx_frame_err); end
  endtask

  task automatic test_glitch;
    push_q.delete();
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL glitch_push: got %0d pushes expected 0", push_q.size()); end
    n_checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags: got %b expected 00", {rx_overrun, rx_frame_err}); end
    n_checks++; if (rx_state_dbg !== 2'd0) begin n_fail++; $display("FAIL glitch_rx_state: got %0d expected 0", rx_state_dbg); end
  endtask

  task automatic test_tx_byte;
    int got_pop, line_err, busy_cnt, busy_first, extra_pops;
    logic t2_line, t3_line;
    tx_frame(8'h3C, 2 + 10 * CPB + 8, got_pop, line_err, busy_cnt, busy_first, t2_line, t3_line, extra_pops);
    n_checks++; if (got_pop !== 1) begin n_fail++; $display("FAIL tx_pop_seen: got %0d expected 1", got_pop); end
    n_checks++; if (t2_line !== 1'b1) begin n_fail++; $display("FAIL tx_line_t2: got %b expected 1", t2_line); end
    n_checks++; if (t3_line !== 1'b0) begin n_fail++; $display("FAIL tx_start_t3: got %b expected 0", t3_line); end
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL tx_line_bits: got %0d bad cycles expected 0", line_err); end
    n_checks++; if (busy_cnt !== 162) begin n_fail++; $display("FAIL tx_busy_span: got %0d expected 162", busy_cnt); end
    n_checks++; if (busy_first !== 1) begin n_fail++; $display("FAIL tx_busy_first: got %0d expected 1", busy_first); end
    n_checks++; if (extra_pops !== 0) begin n_fail++; $display("FAIL tx_extra_pops: got %0d expected 0", extra_pops); end
  endtask

  task automatic test_back_to_back;
    int second_t;
    logic l165, l166, busy163;
    int i;
    int got;
    second_t = 0; l165 = 1'bx; l166 = 1'bx; busy163 = 1'bx; got = 0;
    @(posedge clk); #1 fifo_empty = 1'b0;
    i = 0;
    while (got == 0 && i < 40) begin
      @(negedge clk);
      if (read_fifo) got = 1;
      i++;
    end
    @(posedge clk); #1 fifo_out = 8'hA1;
    if (got == 1) begin
      for (int t = 1; t <= 175; t++) begin
        @(negedge clk);
        if (t == 163) busy163 = tx_busy;
        if (t == 165) l165 = uart_tx;
        if (t == 166) l166 = uart_tx;
        if (read_fifo && second_t == 0) begin
          second_t = t;
          @(posedge clk); #1;
          fifo_empty = 1'b1;
          fifo_out = 8'hB2;
          t++;
          @(negedge clk);
          if (t == 165) l165 = uart_tx;
        end
      end
    end
    fifo_empty = 1'b1;
    repeat (10 * CPB + 10) @(negedge clk);
    n_checks++; if (second_t !== 163) begin n_fail++; $display("FAIL b2b_second_pop: got t=%0d expected 163", second_t); end
    n_checks++; if (busy163 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy163); end
    n_checks++; if ({l165, l166} !== 2'b10) begin n_fail++; $display("FAIL b2b_second_start: got %b expected 10", {l165, l166}); end
  endtask

  task automatic test_backpressure;
    push_q.delete(); exp_q.delete();
    @(posedge clk); #1 fifo_full = 1'b1;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_push: got %0d pushes expected 0", push_q.size()); end
    n_checks++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b expected 1", rx_overrun); end
    exp_q.push_back(8'h11);
    @(posedge clk); #1 fifo_full = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (push_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_release_count: got %0d expected %0d", push_q.size(), exp_q.size()); end
    if (push_q.size() > 0) begin
      n_checks++; if (push_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_release_data: got %h expected %h", push_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_framing;
    push_q.delete();
    send_byte(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL frame_no_push: got %0d pushes expected 0", push_q.size()); end
    n_checks++; if (rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_flag: got %b expected 1", rx_frame_err); end
    n_checks++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL frame_overrun_sticky: got %b expected 1", rx_overrun); end
  endtask

  task automatic test_reset_mid_frame;
    int got_pop, line_err, busy_cnt, busy_first, extra_pops;
    logic t2_line, t3_line;
    // Stop inside data bit 4 (t = 3 + 5*CPB .. 2 + 6*CPB).
    tx_frame(8'h96, 3 + 5 * CPB + 7, got_pop, line_err, busy_cnt, busy_first, t2_line, t3_line, extra_pops);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL rstmid_pre_line: got %0d bad cycles expected 0", line_err); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_uart_tx: got %b expected 1", uart_tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_busy: got %b expected 0", tx_busy); end
    n_checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 00", {rx_overrun, rx_frame_err}); end
    @(posedge clk); #1 rst = 1'b0;
    push_q.delete(); exp_q.delete();
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (push_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_rx_count: got %0d expected %0d", push_q.size(), exp_q.size()); end
    if (push_q.size() > 0) begin
      n_checks++; if (push_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected %h", push_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_full_duplex;
    int got_pop, line_err, busy_cnt, busy_first, extra_pops;
    logic t2_line, t3_line;
    push_q.delete(); exp_q.delete();
    exp_q.push_back(8'hF0);
    fork
      send_byte(8'hF0, 1'b1);
      tx_frame(8'h0F, 2 + 10 * CPB + 8, got_pop, line_err, busy_cnt, busy_first, t2_line, t3_line, extra_pops);
    join
    repeat (10) @(negedge clk);
    n_checks++; if (got_pop !== 1) begin n_fail++; $display("FAIL fd_pop_seen: got %0d expected 1", got_pop); end
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL fd_tx_line: got %0d bad cycles expected 0", line_err); end
    n_checks++; if (busy_cnt !== 162) begin n_fail++; $display("FAIL fd_tx_busy_span: got %0d expected 162", busy_cnt); end
    n_checks++; if (push_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fd_rx_count: got %0d expected %0d", push_q.size(), exp_q.size()); end
    if (push_q.size() > 0) begin
      n_checks++; if (push_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL fd_rx_data: got %h expected %h", push_q[0], exp_q[0]); end
    end
    n_checks++; if (strobe_viol !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d double-wide strobes expected 0", strobe_viol); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_tx_byte();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_mid_frame();
    test_full_duplex();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
